// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: chip patterns, dibit type and transmitter states.
// The decoder imports the same pattern constants so both ends agree on the mapping.
package qpsk_pkg;

    localparam int CHIPS_PER_SYM = 8;

    localparam logic [7:0] PAT_00 = 8'b1111_0000;
    localparam logic [7:0] PAT_01 = 8'b1100_0011;
    localparam logic [7:0] PAT_10 = 8'b0000_1111;
    localparam logic [7:0] PAT_11 = 8'b0011_1100;

    typedef logic [1:0] dibit_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    function automatic logic [7:0] chip_pattern(input dibit_t d);
        logic [7:0] p;
        case (d)
            2'b00:   p = PAT_00;
            2'b01:   p = PAT_01;
            2'b10:   p = PAT_10;
            default: p = PAT_11;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/qpsk_dibit_pack.sv
// Serial-to-dibit packer with a single pending-dibit register feeding the transmitter.
// Holds at most one half pair plus one complete pair; stalls the source when both are full.
module qpsk_dibit_pack
    import qpsk_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   din,
    input  logic   din_valid,
    output logic   din_ready,
    input  logic   consume,
    output logic   pend_v,
    output dibit_t pend_dibit
);

    logic half_v;
    logic hold_bit;
    logic accept;

    // Ready depends only on registers, so a consume and a pair completion never share an edge.
    assign din_ready = !(pend_v && half_v);
    assign accept    = din_valid && din_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_v     <= 1'b0;
            hold_bit   <= 1'b0;
            pend_v     <= 1'b0;
            pend_dibit <= 2'b00;
        end else begin
            if (consume) begin
                pend_v <= 1'b0;
            end
            if (accept) begin
                if (!half_v) begin
                    hold_bit <= din;
                    half_v   <= 1'b1;
                end else begin
                    pend_dibit <= {hold_bit, din};
                    pend_v     <= 1'b1;
                    half_v     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/qpsk_encode.sv
// QPSK chip-pattern modulator: packs serial bits into dibits and emits each as
// an 8-chip pattern, MSB first, one registered chip per clock.
module qpsk_encode
    import qpsk_pkg::*;
#(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic din_valid,
    output logic din_ready,
    output logic qpsk_out,
    output logic sym_start,
    output logic tx_busy,
    output logic underrun
);

    logic        pend_v;
    dibit_t      pend_dibit;
    logic        load;

    tx_state_t   state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic [7:0]  sym_reg, sym_n;
    logic [7:0]  pat;
    logic        out_n;
    logic        start_n;
    logic        under_n;

    qpsk_dibit_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .consume    (load),
        .pend_v     (pend_v),
        .pend_dibit (pend_dibit)
    );

    assign pat = chip_pattern(pend_dibit);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sym_n   = sym_reg;
        out_n   = qpsk_out;
        start_n = 1'b0;
        under_n = 1'b0;
        load    = 1'b0;

        case (state)
            IDLE: begin
                out_n = IDLE_LEVEL;
                if (pend_v) begin
                    load = 1'b1;
                end
            end
            SEND: begin
                if (cnt != 3'd7) begin
                    cnt_n = cnt + 3'd1;
                    out_n = sym_reg[3'd6 - cnt];
                end else if (pend_v) begin
                    load = 1'b1;
                end else begin
                    out_n   = IDLE_LEVEL;
                    state_n = IDLE;
                    under_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                out_n   = IDLE_LEVEL;
            end
        endcase

        // Chip 0 goes out on the same edge that captures the pattern, so back-to-back symbols have no gap.
        if (load) begin
            sym_n   = pat;
            out_n   = pat[7];
            cnt_n   = 3'd0;
            start_n = 1'b1;
            state_n = SEND;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            sym_reg   <= 8'd0;
            qpsk_out  <= IDLE_LEVEL;
            sym_start <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sym_reg   <= sym_n;
            qpsk_out  <= out_n;
            sym_start <= start_n;
            underrun  <= under_n;
        end
    end

    assign tx_busy = (state == SEND);

endmodule

// File: tb/tb_qpsk_encode.sv
// Directed and random bench for qpsk_encode using a queue-based model of the
// bit packer and chip stream, plus a loopback decode of the captured chips.
module tb_qpsk_encode;

    logic clk;
    logic rst;
    logic din;
    logic din_valid;
    logic din_ready;
    logic qpsk_out;
    logic sym_start;
    logic tx_busy;
    logic underrun;

    int total = 0;
    int bad   = 0;

    // model state
    logic bitq[$];
    logic chipq[$];
    logic sent[$];
    logic decoded[$];
    logic m_out, m_start, m_busy, m_under;

    // loopback capture state
    logic       cap;
    int         cap_k;
    logic [7:0] cap_w;

    qpsk_encode #(.IDLE_LEVEL(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .qpsk_out  (qpsk_out),
        .sym_start (sym_start),
        .tx_busy   (tx_busy),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_pattern(input logic [1:0] d);
        case (d)
            2'b00:   return 8'b11110000;
            2'b01:   return 8'b11000011;
            2'b10:   return 8'b00001111;
            default: return 8'b00111100;
        endcase
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        bitq.delete();
        chipq.delete();
        m_out   = 1'b0;
        m_start = 1'b0;
        m_busy  = 1'b0;
        m_under = 1'b0;
        cap     = 1'b0;
        cap_k   = 0;
    endtask

    task automatic model_update(input logic v, input logic d);
        logic       rdy;
        logic       b1, b0;
        logic [7:0] p;
        rdy     = (bitq.size() != 3);
        m_start = 1'b0;
        m_under = 1'b0;
        if (m_busy && chipq.size() > 0) begin
            m_out = chipq.pop_front();
        end else if (bitq.size() >= 2) begin
            b1 = bitq.pop_front();
            b0 = bitq.pop_front();
            p  = ref_pattern({b1, b0});
            m_out = p[7];
            chipq.delete();
            for (int i = 6; i >= 0; i--) chipq.push_back(p[i]);
            m_start = 1'b1;
            m_busy  = 1'b1;
        end else begin
            if (m_busy) m_under = 1'b1;
            m_busy = 1'b0;
            m_out  = 1'b0;
        end
        if (v && rdy) begin
            bitq.push_back(d);
            sent.push_back(d);
        end
    endtask

    task automatic capture();
        if (sym_start) begin
            cap   = 1'b1;
            cap_k = 0;
        end
        if (cap) begin
            cap_w[7 - cap_k] = qpsk_out;
            cap_k++;
            if (cap_k == 8) begin
                cap = 1'b0;
                case (cap_w)
                    8'b11110000: begin decoded.push_back(1'b0); decoded.push_back(1'b0); end
                    8'b11000011: begin decoded.push_back(1'b0); decoded.push_back(1'b1); end
                    8'b00001111: begin decoded.push_back(1'b1); decoded.push_back(1'b0); end
                    8'b00111100: begin decoded.push_back(1'b1); decoded.push_back(1'b1); end
                    default:     begin decoded.push_back(1'bx); decoded.push_back(1'bx); end
                endcase
            end
        end
    endtask

    // One clock: drive inputs after the falling edge, check outputs at the next falling edge.
    task automatic cyc(input logic v, input logic d, output logic acc);
        din_valid = v;
        din       = d;
        acc       = v && (bitq.size() != 3);
        chk("din_ready", din_ready, bitq.size() != 3);
        @(posedge clk);
        model_update(v, d);
        @(negedge clk);
        chk("qpsk_out", qpsk_out, m_out);
        chk("sym_start", sym_start, m_start);
        chk("tx_busy", tx_busy, m_busy);
        chk("underrun", underrun, m_under);
        capture();
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, a);
    endtask

    task automatic send_bit(input logic b);
        logic a;
        int   n;
        n = 0;
        a = 1'b0;
        while (!a && n < 40) begin
            cyc(1'b1, b, a);
            n++;
        end
        if (!a) chk("send_bit_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] seq;
        logic       a;
        int         guard;

        rst       = 1'b1;
        din       = 1'b1;
        din_valid = 1'b1;
        model_reset();
        sent.delete();
        decoded.delete();
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", din_ready, 1'b1);
        chk("rst_out", qpsk_out, 1'b0);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_start", sym_start, 1'b0);
        chk("rst_under", underrun, 1'b0);
        rst       = 1'b0;
        din_valid = 1'b0;
        idle(3);

        // single pair 1,0 -> 00001111 then underrun
        send_bit(1'b1);
        send_bit(1'b0);
        idle(12);

        // four dibits streamed back to back
        seq = 8'b00011011;
        for (int i = 7; i >= 0; i--) send_bit(seq[i]);
        idle(40);

        // gap between bits of a pair after a symbol
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        idle(20);
        send_bit(1'b1);
        idle(12);

        // async reset mid-symbol
        send_bit(1'b0);
        send_bit(1'b1);
        idle(4);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out", qpsk_out, 1'b0);
        chk("midrst_busy", tx_busy, 1'b0);
        chk("midrst_start", sym_start, 1'b0);
        chk("midrst_ready", din_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        send_bit(1'b1);
        send_bit(1'b1);
        idle(12);

        // random loopback of 64 bits
        sent.delete();
        decoded.delete();
        guard = 0;
        while (sent.size() < 64 && guard < 3000) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, a);
            guard++;
        end
        idle(40);
        total++;
        assert (decoded.size() == sent.size() && sent.size() == 64) else begin
            bad++;
            $error("FAIL loop_len observed=%0d expected=%0d", decoded.size(), sent.size());
        end
        for (int i = 0; i < sent.size() && i < decoded.size(); i++) begin
            chk("loop_bit", decoded[i], sent[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
